// File: rtl/pair_game_ctrl_pkg.sv
// Shared types and sizing for the pair-matching game controller.
package pair_game_ctrl_pkg;

  localparam int NUM_CARDS = 6;
  localparam int CARD_W    = 4;
  localparam int IDX_W     = 3;

  typedef enum logic [2:0] {
    IDLE, GEN, PICK1, PICK2, COMPARE, HOLD, WIN, LOSE
  } state_t;

  // One-hot card bit; indices beyond the last card yield an empty mask.
  function automatic logic [NUM_CARDS-1:0] idx_bit(input logic [IDX_W-1:0] idx);
    return NUM_CARDS'(1) << idx;
  endfunction

endpackage

// File: rtl/pair_game_ctrl_if.sv
// Pair generator and player-selection signals; slave side is the game controller.
interface pair_game_ctrl_if;
  import pair_game_ctrl_pkg::*;

  logic              gen_enable;
  logic              gen_done;
  logic [CARD_W-1:0] card_a, card_b, card_c, card_d, card_e, card_f;
  logic              sel_valid;
  logic [IDX_W-1:0]  sel_idx;

  modport slave (
    input  gen_done, card_a, card_b, card_c, card_d, card_e, card_f,
    input  sel_valid, sel_idx,
    output gen_enable
  );

  modport master (
    output gen_done, card_a, card_b, card_c, card_d, card_e, card_f,
    output sel_valid, sel_idx,
    input  gen_enable
  );

endinterface

// File: rtl/pair_game_ctrl_hold_timer.sv
// Reveal hold countdown: load arms HOLD_CYCLES-1, done fires on the last enabled cycle.
// No flow control; done is combinational from the count and en.
module hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(HOLD_CYCLES - 1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign done = en && (cnt == '0);

endmodule

// File: rtl/pair_game_ctrl.sv
// Pair-matching game FSM: latches six cards, takes two picks, then matches or holds the reveal.
// Match updates matched_mask two edges after the second pick; selections are single-cycle pulses, no backpressure.
module pair_game_ctrl
  import pair_game_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int MAX_MISSES  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  pair_game_ctrl_if.slave      bus,
  output logic [NUM_CARDS-1:0] reveal_mask,
  output logic [NUM_CARDS-1:0] matched_mask,
  output logic [1:0]           match_count,
  output logic [3:0]           miss_count,
  output logic                 busy,
  output logic                 game_win,
  output logic                 game_lose
);

  state_t                           state_q, state_d;
  logic [NUM_CARDS-1:0][CARD_W-1:0] cards_q, cards_d, cards_in;
  logic [IDX_W-1:0]                 first_q, first_d, second_q, second_d;
  logic [NUM_CARDS-1:0]             reveal_q, reveal_d, matched_q, matched_d;
  logic [NUM_CARDS-1:0]             sel_bit, pair_bits;
  logic [1:0]                       match_q, match_d;
  logic [3:0]                       miss_q, miss_d;
  logic                             sel_ok, hold_load, hold_done;

  assign cards_in = {bus.card_f, bus.card_e, bus.card_d, bus.card_c, bus.card_b, bus.card_a};
  assign sel_bit  = idx_bit(bus.sel_idx);
  // Out-of-range indices, matched cards and face-up cards are all refused.
  assign sel_ok   = bus.sel_valid && (bus.sel_idx < IDX_W'(NUM_CARDS)) &&
                    ((sel_bit & (reveal_q | matched_q)) == '0);

  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
    .clk  (clk),
    .rst  (rst),
    .load (hold_load),
    .en   (state_q == HOLD),
    .done (hold_done)
  );

  always_comb begin
    state_d   = state_q;
    cards_d   = cards_q;
    first_d   = first_q;
    second_d  = second_q;
    reveal_d  = reveal_q;
    matched_d = matched_q;
    match_d   = match_q;
    miss_d    = miss_q;
    hold_load = 1'b0;
    pair_bits = idx_bit(first_q) | idx_bit(second_q);

    case (state_q)
      IDLE, WIN, LOSE: begin
        if (start) begin
          state_d   = GEN;
          reveal_d  = '0;
          matched_d = '0;
          match_d   = '0;
          miss_d    = '0;
        end
      end
      GEN: begin
        if (bus.gen_done) begin
          cards_d = cards_in;
          state_d = PICK1;
        end
      end
      PICK1: begin
        if (sel_ok) begin
          reveal_d = reveal_q | sel_bit;
          first_d  = bus.sel_idx;
          state_d  = PICK2;
        end
      end
      PICK2: begin
        if (sel_ok) begin
          reveal_d = reveal_q | sel_bit;
          second_d = bus.sel_idx;
          state_d  = COMPARE;
        end
      end
      COMPARE: begin
        if (cards_q[first_q] == cards_q[second_q]) begin
          reveal_d  = reveal_q & ~pair_bits;
          matched_d = matched_q | pair_bits;
          match_d   = match_q + 2'd1;
          state_d   = (match_q == 2'd2) ? WIN : PICK1;
        end else begin
          hold_load = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (hold_done) begin
          reveal_d = '0;
          miss_d   = (miss_q < 4'(MAX_MISSES)) ? miss_q + 4'd1 : miss_q;
          state_d  = (miss_q >= 4'(MAX_MISSES - 1)) ? LOSE : PICK1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cards_q   <= '0;
      first_q   <= '0;
      second_q  <= '0;
      reveal_q  <= '0;
      matched_q <= '0;
      match_q   <= '0;
      miss_q    <= '0;
    end else begin
      state_q   <= state_d;
      cards_q   <= cards_d;
      first_q   <= first_d;
      second_q  <= second_d;
      reveal_q  <= reveal_d;
      matched_q <= matched_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
    end
  end

  assign bus.gen_enable = (state_q == GEN);
  assign reveal_mask    = reveal_q;
  assign matched_mask   = matched_q;
  assign match_count    = match_q;
  assign miss_count     = miss_q;
  assign busy           = !(state_q inside {IDLE, WIN, LOSE});
  assign game_win       = (state_q == WIN);
  assign game_lose      = (state_q == LOSE);

endmodule

// File: tb/tb_pair_game_ctrl.sv
// Bench for pair_game_ctrl: directed scenarios plus random games against a rule-level game model.
module tb_pair_game_ctrl;

  localparam int HOLD = 4;
  localparam int MAXM = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [5:0] reveal_mask, matched_mask;
  logic [1:0] match_count;
  logic [3:0] miss_count;
  logic       busy, game_win, game_lose;

  pair_game_ctrl_if bus();

  pair_game_ctrl #(.HOLD_CYCLES(HOLD), .MAX_MISSES(MAXM)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus),
    .reveal_mask  (reveal_mask),
    .matched_mask (matched_mask),
    .match_count  (match_count),
    .miss_count   (miss_count),
    .busy         (busy),
    .game_win     (game_win),
    .game_lose    (game_lose)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Game model: what the player should see, tracked by the rules of the game.
  logic [3:0] m_cards [6];
  logic [5:0] m_reveal, m_matched;
  int         m_match, m_miss, m_npicks, m_first, m_second;
  bit         m_busy, m_win, m_lose, m_gen;

  logic [21:0] obs;
  assign obs = {reveal_mask, matched_mask, match_count, miss_count, busy, game_win, game_lose, bus.gen_enable};

  function automatic logic [21:0] exp_vec();
    return {m_reveal, m_matched, 2'(m_match), 4'(m_miss), m_busy, m_win, m_lose, m_gen};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_reveal = '0; m_matched = '0; m_match = 0; m_miss = 0; m_npicks = 0;
    m_busy = 0; m_win = 0; m_lose = 0; m_gen = 0;
  endtask

  task automatic noise_on();
    bus.sel_valid = 1'b1;
    bus.sel_idx   = 3'($urandom_range(0, 7));
    start         = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset(input int cycles, input string nm);
    rst = 1'b0;
    #1;
    model_clear();
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL %s_async: got %h expected %h", nm, obs, exp_vec()); end
    repeat (cycles) step();
    rst = 1'b1;
    step();
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL %s_release: got %h expected %h", nm, obs, exp_vec()); end
  endtask

  task automatic pulse_start(input string nm);
    start = 1'b1;
    step();
    start = 1'b0;
    if (!m_busy) begin
      model_clear();
      m_busy = 1; m_gen = 1;
    end
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs, exp_vec()); end
  endtask

  task automatic gen_finish(input int delay, input logic [3:0] v [6], input string nm);
    for (int k = 1; k < delay; k++) begin
      noise_on();
      start = 1'b0;
      step();
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL %s_gen%0d: got %h expected %h", nm, k, obs, exp_vec()); end
    end
    bus.sel_valid = 1'b0;
    {bus.card_a, bus.card_b, bus.card_c} = {v[0], v[1], v[2]};
    {bus.card_d, bus.card_e, bus.card_f} = {v[3], v[4], v[5]};
    bus.gen_done = 1'b1;
    step();
    bus.gen_done = 1'b0;
    if (m_gen) begin
      m_gen = 0;
      for (int i = 0; i < 6; i++) m_cards[i] = v[i];
    end
    // Card inputs must be irrelevant once latched.
    {bus.card_a, bus.card_b, bus.card_c} = 12'($urandom);
    {bus.card_d, bus.card_e, bus.card_f} = 12'($urandom);
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL %s_latch: got %h expected %h", nm, obs, exp_vec()); end
  endtask

  task automatic pick(input int idx, input string nm);
    bit acc;
    logic [5:0] pair;
    bus.sel_valid = 1'b1;
    bus.sel_idx   = 3'(idx);
    step();
    bus.sel_valid = 1'b0;
    acc = 0;
    if (m_busy && !m_gen && idx < 6) acc = !m_matched[idx] && !m_reveal[idx];
    if (acc) begin
      m_reveal[idx] = 1'b1;
      if (m_npicks == 0) begin m_first = idx; m_npicks = 1; end
      else begin m_second = idx; m_npicks = 2; end
    end
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL %s_pick%0d: got %h expected %h", nm, idx, obs, exp_vec()); end
    if (m_npicks == 2) begin
      m_npicks = 0;
      pair = (6'b1 << m_first) | (6'b1 << m_second);
      noise_on();
      step();
      if (m_cards[m_first] == m_cards[m_second]) begin
        m_reveal  = m_reveal & ~pair;
        m_matched = m_matched | pair;
        m_match++;
        if (m_match == 3) begin m_busy = 0; m_win = 1; end
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL %s_match: got %h expected %h", nm, obs, exp_vec()); end
      end else begin
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL %s_hold1: got %h expected %h", nm, obs, exp_vec()); end
        for (int k = 2; k <= HOLD; k++) begin
          noise_on();
          step();
          checks++;
          if (obs !== exp_vec()) begin errors++; $display("FAIL %s_hold%0d: got %h expected %h", nm, k, obs, exp_vec()); end
        end
        noise_on();
        step();
        m_reveal = '0;
        if (m_miss < MAXM) m_miss++;
        if (m_miss == MAXM) begin m_busy = 0; m_lose = 1; end
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL %s_hold_exit: got %h expected %h", nm, obs, exp_vec()); end
      end
      bus.sel_valid = 1'b0;
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset(2, "reset_init");
    pulse_start("reset_start");
    step();
    checks++;
    if (obs !== exp_vec()) begin errors++; $display("FAIL reset_in_gen: got %h expected %h", obs, exp_vec()); end
    do_reset(4, "reset_mid_gen");
    if (bus.gen_enable !== 1'b0 || obs !== 22'd0) begin
      errors++; $display("FAIL reset_all_zero: got %h expected 0", obs);
    end
    checks++;
    pick(0, "idle_ignored");
    pulse_start("fresh_start");
    gen_finish(2, '{4'd7, 4'd8, 4'd9, 4'd7, 4'd8, 4'd9}, "fresh_gen");
    pick(2, "fresh");
    pick(5, "fresh");
  endtask

  task automatic test_gen_match();
    do_reset(1, "gm_reset");
    pulse_start("gm_start");
    gen_finish(3, '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3}, "gm");
    pick(0, "gm");
    pick(3, "gm");
    checks++;
    if (matched_mask !== 6'b001001 || match_count !== 2'd1) begin
      errors++; $display("FAIL gm_result: got matched=%b count=%0d expected 001001/1", matched_mask, match_count);
    end
  endtask

  task automatic test_mismatch_hold();
    do_reset(1, "mh_reset");
    pulse_start("mh_start");
    gen_finish(1, '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3}, "mh");
    pick(0, "mh");
    pick(1, "mh");
    checks++;
    if (reveal_mask !== 6'b0 || miss_count !== 4'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL mh_result: got reveal=%b miss=%0d busy=%b expected 0/1/1", reveal_mask, miss_count, busy);
    end
  endtask

  task automatic test_reject();
    do_reset(1, "rj_reset");
    pulse_start("rj_start");
    gen_finish(2, '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3}, "rj");
    pick(0, "rj_first");
    pick(0, "rj_repeat");
    pick(7, "rj_range");
    checks++;
    if (reveal_mask !== 6'b000001) begin
      errors++; $display("FAIL rj_mask: got %b expected 000001", reveal_mask);
    end
    pick(3, "rj_second");
    pick(0, "rj_matched");
    pick(3, "rj_matched");
    pick(6, "rj_range6");
  endtask

  task automatic test_win_restart();
    do_reset(1, "wn_reset");
    pulse_start("wn_start");
    gen_finish(2, '{4'd5, 4'd9, 4'd12, 4'd5, 4'd9, 4'd12}, "wn");
    pick(0, "wn"); pick(3, "wn");
    pick(1, "wn"); pick(4, "wn");
    pick(2, "wn"); pick(5, "wn");
    checks++;
    if (game_win !== 1'b1 || busy !== 1'b0 || match_count !== 2'd3) begin
      errors++; $display("FAIL wn_state: got win=%b busy=%b count=%0d expected 1/0/3", game_win, busy, match_count);
    end
    pick(1, "wn_ignored");
    pulse_start("wn_restart");
    checks++;
    if (bus.gen_enable !== 1'b1 || matched_mask !== 6'b0 || match_count !== 2'd0 || miss_count !== 4'd0) begin
      errors++; $display("FAIL wn_cleared: got %h expected gen only", obs);
    end
    gen_finish(1, '{4'd3, 4'd3, 4'd4, 4'd4, 4'd6, 4'd6}, "wn2");
  endtask

  task automatic test_lose();
    do_reset(1, "ls_reset");
    pulse_start("ls_start");
    gen_finish(2, '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3}, "ls");
    pick(0, "ls"); pick(1, "ls");
    pick(2, "ls"); pick(3, "ls");
    checks++;
    if (game_lose !== 1'b1 || miss_count !== 4'd2 || busy !== 1'b0) begin
      errors++; $display("FAIL ls_state: got lose=%b miss=%0d busy=%b expected 1/2/0", game_lose, miss_count, busy);
    end
    pick(4, "ls_ignored");
    pick(0, "ls_ignored");
    pulse_start("ls_restart");
  endtask

  task automatic test_random_games();
    logic [3:0] v [6];
    logic [3:0] tmp;
    int idx, n;
    for (int g = 0; g < 12; g++) begin
      if (m_busy) do_reset(1 + g % 3, "rnd_reset");
      pulse_start("rnd_start");
      for (int p = 0; p < 3; p++) begin
        v[2*p]   = 4'($urandom_range(0, 15));
        v[2*p+1] = v[2*p];
      end
      for (int i = 5; i > 0; i--) begin
        int j = $urandom_range(0, i);
        tmp = v[i]; v[i] = v[j]; v[j] = tmp;
      end
      gen_finish($urandom_range(1, 4), v, "rnd");
      n = 0;
      while (m_busy && n < 80) begin
        idx = $urandom_range(0, 7);
        if (m_npicks == 1 && $urandom_range(0, 3) != 0) begin
          for (int j = 0; j < 6; j++)
            if (j != m_first && !m_matched[j] && !m_reveal[j] && m_cards[j] == m_cards[m_first]) idx = j;
        end
        pick(idx, "rnd");
        n++;
      end
    end
  endtask

  initial begin
    bus.gen_done  = 1'b0;
    bus.sel_valid = 1'b0;
    bus.sel_idx   = '0;
    {bus.card_a, bus.card_b, bus.card_c, bus.card_d, bus.card_e, bus.card_f} = '0;
    model_clear();
    #2;
    test_reset();
    test_gen_match();
    test_mismatch_hold();
    test_reject();
    test_win_restart();
    test_lose();
    test_random_games();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pair_game_ctrl.md
PAIR_GAME_CTRL -- requirements
Module: pair_game_ctrl

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, number of cycles a mismatched pair stays revealed.
REQ-002 Parameter MAX_MISSES, default 8, number of mismatches that ends the game as a loss.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse from debounced button; begins or restarts a game.
REQ-006 gen_done  input  1  pair generator finished (endState of pair generator).
REQ-007 card_a..card_f  input  4 each  card values from pair generator (A..F).
REQ-008 sel_valid  input  1  one-cycle pulse; player selects card sel_idx.
REQ-009 sel_idx  input  3  selected card index, 0..5 (0=A ... 5=F).
REQ-010 gen_enable  output  1  enable to pair generator.
REQ-011 reveal_mask  output  6  bit i high: card i currently face-up (temporary).
REQ-012 matched_mask  output  6  bit i high: card i permanently matched.
REQ-013 match_count  output  2  pairs matched, 0..3.
REQ-014 miss_count  output  4  mismatches this game, saturates at MAX_MISSES.
REQ-015 busy  output  1  high when state is not IDLE, WIN or LOSE.
REQ-016 game_win / game_lose  output  1 each  high while in WIN / LOSE.

Function
REQ-017 States: IDLE, GEN, PICK1, PICK2, COMPARE, HOLD, WIN, LOSE.
REQ-018 IDLE -> GEN on start; WIN or LOSE -> GEN on start; start ignored in all other states.
REQ-019 Entering GEN clears reveal_mask, matched_mask, match_count, miss_count.
REQ-020 gen_enable high for every cycle in GEN, low in all other states.
REQ-021 In GEN, gen_done high -> card_a..card_f latched into internal card registers same edge; next state PICK1.
REQ-022 After latching, the game uses only internal card registers; input changes are ignored.
REQ-023 PICK1: accepted sel_valid sets reveal_mask[sel_idx], stores first index, -> PICK2.
REQ-024 PICK2: accepted sel_valid sets reveal_mask[sel_idx], stores second index, -> COMPARE.
REQ-025 A selection is rejected with no state change if sel_idx > 5, the card is matched, or the card is already revealed (covers repeating the first pick).
REQ-026 sel_valid ignored in GEN, COMPARE, HOLD, IDLE, WIN, LOSE.
REQ-027 COMPARE lasts exactly one cycle; a match is decided when the two latched 4-bit values are equal.
REQ-028 On match: both bits move from reveal_mask to matched_mask and match_count increments, same edge; -> WIN when new match_count is 3, else PICK1.
REQ-029 On mismatch: -> HOLD with both cards still revealed; hold counter loaded to HOLD_CYCLES-1.
REQ-030 HOLD lasts exactly HOLD_CYCLES cycles; on leaving, reveal_mask clears and miss_count increments, same edge.
REQ-031 HOLD exit -> LOSE when new miss_count equals MAX_MISSES, else PICK1.
REQ-032 WIN and LOSE hold matched_mask, match_count, miss_count until next start.
REQ-033 Latency from accepted second pick to matched_mask update is 2 edges (PICK2->COMPARE->PICK1/WIN).

Reset
REQ-034 rst low asynchronously forces IDLE; gen_enable, reveal_mask, matched_mask, match_count, miss_count, hold counter and card registers all zero.
REQ-035 Reset asserted mid-game (any state) aborts it with no residual state; first start after release begins a fresh GEN.

Structure
REQ-036 Shared package holds the state enumeration, NUM_CARDS=6, CARD_W=4, IDX_W=3.
REQ-037 The hold countdown is one sub-module, hold_timer (load, count-down, done pulse); the rest is a single FSM plus registers.

Verification
REQ-038 Reset low 4 cycles mid-GEN, then high -> all outputs zero, state IDLE, gen_enable 0.
REQ-039 start, gen_done after 3 cycles with cards 1,2,3,1,2,3 -> gen_enable high exactly 3 cycles and low from the gen_done edge; picks 0,3 -> matched_mask=6'b001001, match_count=1.
REQ-040 Same cards, picks 0,1 -> reveal_mask=6'b000011 for exactly 4 cycles in HOLD, then 0; miss_count=1.
REQ-041 Picks 0,0 and then 7 -> both rejected, state stays PICK2 with reveal_mask=6'b000001; sel_valid during HOLD -> no change.
REQ-042 Matching pairs (0,3),(1,4),(2,5) -> game_win=1, busy=0; start -> GEN with all counters cleared.
REQ-043 MAX_MISSES=2, two mismatches -> game_lose=1 after second HOLD, miss_count=2; further sel_valid ignored.
